// File: rtl/if_prefetch_buf.sv
// rtl/if_prefetch_buf.sv - instruction prefetch buffer; optional rdata forwarding when IFBUF_FWD_EN is defined
module if_prefetch_buf #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [31:0] flush_addr_i,
  input  logic        hold_i,
  output logic        req_o,
  output logic [31:0] addr_o,
  input  logic        gnt_i,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_ready_i
);

  localparam int AW  = $clog2(DEPTH);
  // Discards are not covered by fetch credit, so repeated flushes against a
  // slow bus can pile up more than DEPTH of them; give the counter headroom.
  localparam int DCW = 16;

  logic [31:0]    r_pc;
  logic [31:0]    r_raddr;
  logic [AW:0]    r_count;
  logic [AW:0]    r_outstanding;
  logic [DCW-1:0] r_discard;
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [31:0]    r_mem_data [DEPTH];
  logic [31:0]    r_mem_addr [DEPTH];

  logic w_credit;
  logic w_grant;
  logic w_disc_zero;
  logic w_resp_keep;
  logic w_ret;
  logic w_head_valid;
  logic w_push;
  logic w_pop;

  assign w_credit     = ({1'b0, r_count} + {1'b0, r_outstanding}) < (AW+2)'(DEPTH);
  assign req_o        = !rst && !flush_i && !hold_i && w_credit;
  assign addr_o       = r_pc;
  assign w_grant      = req_o && gnt_i;
  assign w_disc_zero  = (r_discard == '0);
  // A response belongs to the live stream only when no discards are pending.
  assign w_ret        = rvalid_i && w_disc_zero;
  assign w_resp_keep  = w_ret && !flush_i;
  assign w_head_valid = (r_count != '0);
  assign w_pop        = w_head_valid && inst_ready_i && !flush_i;

`ifdef IFBUF_FWD_EN
  logic w_fwd;
  assign w_fwd        = !rst && !w_head_valid && w_resp_keep;
  assign w_push       = w_resp_keep && !(w_fwd && inst_ready_i);
  assign inst_valid_o = w_head_valid || w_fwd;
  assign inst_o       = w_head_valid ? r_mem_data[r_rptr] : (w_fwd ? rdata_i : 32'h0);
  assign inst_addr_o  = w_head_valid ? r_mem_addr[r_rptr] : (w_fwd ? r_raddr : 32'h0);
`else
  assign w_push       = w_resp_keep;
  assign inst_valid_o = w_head_valid;
  assign inst_o       = w_head_valid ? r_mem_data[r_rptr] : 32'h0;
  assign inst_addr_o  = w_head_valid ? r_mem_addr[r_rptr] : 32'h0;
`endif

  // Fetch PC and the address of the next live response (responses return in order).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_ADDR;
      r_raddr <= RESET_ADDR;
    end else if (flush_i) begin
      r_pc    <= flush_addr_i;
      r_raddr <= flush_addr_i;
    end else begin
      if (w_grant) begin
        r_pc <= r_pc + 32'd4;
      end
      if (w_resp_keep) begin
        r_raddr <= r_raddr + 32'd4;
      end
    end
  end

  // Bus bookkeeping: a flush moves every live in-flight request into the discard count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outstanding <= '0;
      r_discard     <= '0;
    end else if (flush_i) begin
      r_outstanding <= '0;
      r_discard     <= r_discard + {{(DCW-AW-1){1'b0}}, r_outstanding}
                       - {{(DCW-1){1'b0}}, rvalid_i};
    end else begin
      r_outstanding <= r_outstanding + {{AW{1'b0}}, w_grant} - {{AW{1'b0}}, w_ret};
      if (rvalid_i && !w_disc_zero) begin
        r_discard <= r_discard - {{(DCW-1){1'b0}}, 1'b1};
      end
    end
  end

  // FIFO pointers and occupancy; flush empties the buffer and ignores any pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else if (flush_i) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage: instruction word plus the address it was fetched from.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wptr] <= rdata_i;
      r_mem_addr[r_wptr] <= r_raddr;
    end
  end

endmodule

// File: tb/tb_if_prefetch_buf.sv
// tb/tb_if_prefetch_buf.sv - self-checking bench for if_prefetch_buf
module tb_if_prefetch_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic [31:0] flush_addr_i = 32'h0;
  logic        hold_i = 1'b0;
  logic        req_o;
  logic [31:0] addr_o;
  logic        gnt_i = 1'b0;
  logic        rvalid_i = 1'b0;
  logic [31:0] rdata_i = 32'h0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_ready_i = 1'b0;

  if_prefetch_buf #(.DEPTH(4), .RESET_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .flush_addr_i(flush_addr_i),
    .hold_i(hold_i), .req_o(req_o), .addr_o(addr_o), .gnt_i(gnt_i),
    .rvalid_i(rvalid_i), .rdata_i(rdata_i), .inst_valid_o(inst_valid_o),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_ready_i(inst_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        hold;
    logic        ready;
    logic        gnt;
    int          cycles;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic        chk_iaddr;
    logic [31:0] exp_iaddr;
    int          exp_grants;
  } phase_t;

  int          checks = 0;
  int          errors = 0;
  int          grants = 0;
  bit          bus_stall = 1'b0;
  logic [31:0] bus_q[$];
  exp_t        sb_q[$];
  phase_t      tbl[4];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF ^ {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      #3;
      if (inst_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: inst_valid_o stayed 0, required 1 within 20 cycles", name);
    end
  endtask

  task automatic do_reset(input bit check);
    rst = 1'b1; flush_i = 1'b0; hold_i = 1'b0; gnt_i = 1'b0;
    inst_ready_i = 1'b0; bus_stall = 1'b0;
    step(2);
    #3;
    if (check) begin
      chk("rst_req", req_o, 0);
      chk("rst_valid", inst_valid_o, 0);
      chk("rst_inst", inst_o, 0);
      chk("rst_iaddr", inst_addr_o, 0);
      chk("rst_addr", addr_o, 32'h0);
    end
    step(1);
    rst = 1'b0;
  endtask

  // Scoreboard: handshakes seen on the falling edge happen at the next rising edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      sb_q.delete();
      bus_q.delete();
    end else begin
      if (inst_valid_o && inst_ready_i && !flush_i) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got inst at %h, required none", inst_addr_o);
        end else begin
          e = sb_q.pop_front();
          chk("sb_addr", inst_addr_o, e.addr);
          chk("sb_data", inst_o, e.data);
        end
      end
      if (flush_i) sb_q.delete();
      if (req_o && gnt_i) begin
        grants++;
        sb_q.push_back('{addr_o, word_of(addr_o)});
        bus_q.push_back(addr_o);
      end
    end
  end

  // Bus model: in-order responses, one cycle after grant unless stalled.
  initial begin : bus
    logic [31:0] a;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        bus_q.delete();
        rvalid_i = 1'b0;
        rdata_i  = 32'h0;
      end else if (!bus_stall && bus_q.size() > 0) begin
        a = bus_q.pop_front();
        rvalid_i = 1'b1;
        rdata_i  = word_of(a);
      end else begin
        rvalid_i = 1'b0;
        rdata_i  = 32'h0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required to finish");
    $fatal(1);
  end

  task automatic flush_seq(input bit twice);
    bit ok;
    do_reset(1'b0);
    gnt_i = 1'b1; inst_ready_i = 1'b1; bus_stall = 1'b1;
    step(2);
    gnt_i = 1'b0; flush_i = 1'b1; flush_addr_i = 32'h100;
    #3;
    chk("flush_req_low", req_o, 0);
    step(1);
    flush_i = 1'b0; gnt_i = 1'b1; bus_stall = twice;
    #3;
    chk("flush_addr_o", addr_o, 32'h100);
    chk("flush_valid_low", inst_valid_o, 0);
    if (twice) begin
      step(1);
      gnt_i = 1'b0; flush_i = 1'b1; flush_addr_i = 32'h300;
      step(1);
      flush_i = 1'b0; gnt_i = 1'b1; bus_stall = 1'b0;
      #3;
      chk("flush2_addr_o", addr_o, 32'h300);
    end
    wait_valid(twice ? "flush2" : "flush1", ok);
    if (ok) begin
      chk(twice ? "flush2_first_iaddr" : "flush1_first_iaddr", inst_addr_o,
          twice ? 32'h300 : 32'h100);
      chk("flush_first_inst", inst_o, word_of(twice ? 32'h300 : 32'h100));
    end
    step(4);
  endtask

  initial begin : main
    bit ok;
    tbl[0] = '{1'b0, 1'b0, 1'b1, 6, 1'b0, 32'd16, 1'b1, 1'b1, 32'd0, 4};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 5, 1'b1, 32'd28, 1'b1, 1'b1, 32'd16, 7};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 5, 1'b0, 32'd32, 1'b0, 1'b0, 32'd0, 8};
`ifdef IFBUF_FWD_EN
    tbl[3] = '{1'b0, 1'b1, 1'b1, 4, 1'b1, 32'd44, 1'b1, 1'b1, 32'd40, 11};
`else
    tbl[3] = '{1'b0, 1'b1, 1'b1, 4, 1'b1, 32'd44, 1'b1, 1'b1, 32'd36, 11};
`endif

    do_reset(1'b1);
    for (int r = 0; r < 4; r++) begin
      if (r > 0) step(1);
      hold_i = tbl[r].hold; inst_ready_i = tbl[r].ready; gnt_i = tbl[r].gnt;
      for (int c = 0; c < tbl[r].cycles; c++) begin
        if (c > 0) step(1);
        #3;
        if (tbl[r].hold) begin
          chk($sformatf("row%0d_hold_pc", r), addr_o, tbl[r].exp_addr);
          chk($sformatf("row%0d_hold_req", r), req_o, 0);
        end
      end
      chk($sformatf("row%0d_req", r), req_o, tbl[r].exp_req);
      chk($sformatf("row%0d_addr", r), addr_o, tbl[r].exp_addr);
      chk($sformatf("row%0d_valid", r), inst_valid_o, tbl[r].exp_valid);
      if (tbl[r].chk_iaddr) chk($sformatf("row%0d_iaddr", r), inst_addr_o, tbl[r].exp_iaddr);
      chk($sformatf("row%0d_grants", r), grants, tbl[r].exp_grants);
    end
    step(1);

    flush_seq(1'b0);
    flush_seq(1'b1);

    // Flush coincident with a response and a pop.
    do_reset(1'b0);
    gnt_i = 1'b1; inst_ready_i = 1'b1;
    step(4);
    flush_i = 1'b1; flush_addr_i = 32'h200;
    step(1);
    flush_i = 1'b0;
    #3;
    chk("coinc_valid_low", inst_valid_o, 0);
    chk("coinc_req", req_o, 1);
    chk("coinc_addr_o", addr_o, 32'h200);
    wait_valid("coinc", ok);
    if (ok) chk("coinc_first_iaddr", inst_addr_o, 32'h200);
    step(3);

    // Response latency into an empty buffer.
    do_reset(1'b0);
    inst_ready_i = 1'b1; bus_stall = 1'b1; gnt_i = 1'b1;
    step(1);
    gnt_i = 1'b0;
    step(2);
    bus_stall = 1'b0;
    #3;
`ifdef IFBUF_FWD_EN
    chk("lat_valid_n", inst_valid_o, 1);
    chk("lat_inst_n", inst_o, word_of(32'h0));
    step(1);
    #3;
    chk("lat_valid_n1", inst_valid_o, 0);
`else
    chk("lat_valid_n", inst_valid_o, 0);
    step(1);
    #3;
    chk("lat_valid_n1", inst_valid_o, 1);
    chk("lat_iaddr_n1", inst_addr_o, 32'h0);
`endif
    step(2);

    // Reset with a buffered entry and a stalled response in flight.
    do_reset(1'b0);
    flush_i = 1'b1; flush_addr_i = 32'h400;
    step(1);
    flush_i = 1'b0; gnt_i = 1'b1;
    step(2);
    gnt_i = 1'b0; bus_stall = 1'b1;
    step(1);
    rst = 1'b1;
    #3;
    chk("midrst_req", req_o, 0);
    chk("midrst_valid", inst_valid_o, 0);
    chk("midrst_inst", inst_o, 0);
    chk("midrst_iaddr", inst_addr_o, 0);
    step(1);
    rst = 1'b0; bus_stall = 1'b0; gnt_i = 1'b1; inst_ready_i = 1'b1;
    #3;
    chk("midrst_addr_o", addr_o, 32'h0);
    wait_valid("midrst", ok);
    if (ok) begin
      chk("midrst_first_iaddr", inst_addr_o, 32'h0);
      chk("midrst_first_inst", inst_o, word_of(32'h0));
    end
    step(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_prefetch_buf.md
IF_PREFETCH_BUF -- requirements
Module: if_prefetch_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter RESET_ADDR, default 32'h0, meaning first fetch address after reset.
REQ-003 SHALL have port clk  input  1  core clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port flush_i  input  1  jump/interrupt redirect; discard all buffered and in-flight instructions.
REQ-006 SHALL have port flush_addr_i  input  32  new fetch address when flush_i=1.
REQ-007 SHALL have port hold_i  input  1  bus hold; suppress new requests while 1.
REQ-008 SHALL have port req_o  output  1  fetch request to bus.
REQ-009 SHALL have port addr_o  output  32  fetch address, word aligned.
REQ-010 SHALL have port gnt_i  input  1  bus accepts request this cycle when req_o=1.
REQ-011 SHALL have port rvalid_i  input  1  response valid; responses return in request order, >=1 cycle after grant.
REQ-012 SHALL have port rdata_i  input  32  instruction word for response.
REQ-013 SHALL have port inst_valid_o  output  1  instruction available to decode.
REQ-014 SHALL have port inst_o  output  32  instruction word.
REQ-015 SHALL have port inst_addr_o  output  32  address of inst_o.
REQ-016 SHALL have port inst_ready_i  input  1  decode consumes entry when inst_valid_o & inst_ready_i.

Function
REQ-017 SHALL hold fetch PC; PC advances by 4 on each req_o & gnt_i cycle, wrapping modulo 2^32.
REQ-018 SHALL track outstanding = granted minus returned responses, width clog2(DEPTH)+1.
REQ-019 SHALL assert req_o = !rst & !flush_i & !hold_i & (fifo_count + outstanding < DEPTH); addr_o = PC.
REQ-020 SHALL store each non-discarded rvalid_i response with its address in FIFO; overflow structurally impossible via REQ-019.
REQ-021 SHALL present FIFO head on inst_o/inst_addr_o with inst_valid_o = (count != 0); pop on inst_valid_o & inst_ready_i.
REQ-022 SHALL support simultaneous push and pop in one cycle, count unchanged; full push blocked only by credit, never dropped.
REQ-023 On flush_i=1: FIFO cleared, PC <= flush_addr_i, discard counter <= outstanding minus (1 if rvalid_i this cycle), inst_valid_o=0 next cycle.
REQ-024 SHALL drop responses while discard counter != 0, decrementing per rvalid_i; a response coincident with flush_i is dropped.
REQ-025 flush_i during nonzero discard count SHALL add current outstanding to it (no lost bookkeeping); pop ignored in flush cycle.
REQ-026 hold_i SHALL not affect responses, discards or the decode side.
REQ-027 Latency without forwarding: response at edge N, inst_valid_o=1 after edge N+1... i.e. in cycle following rvalid_i.

Reset
REQ-028 On rst: PC=RESET_ADDR, FIFO empty, outstanding=0, discard=0; req_o=0, inst_valid_o=0, inst_o=0, inst_addr_o=0 while rst=1.
REQ-029 Reset mid-transaction SHALL abandon in-flight responses; bus is reset concurrently, no stale response accepted.

Configuration
REQ-030 Macro IFBUF_FWD_EN defined: when FIFO empty, rvalid_i=1, no discard and no flush, rdata_i SHALL drive inst_o combinationally with inst_valid_o=1; if inst_ready_i=1 the word is not stored.
REQ-031 Macro IFBUF_FWD_EN undefined: all instructions pass through FIFO registers; no combinational path rvalid_i/rdata_i -> inst_*.

Verification
REQ-032 Reset RESET_ADDR=0, gnt_i=1, 1-cycle responses, ready=1 -> addr_o 0,4,8,...; inst_addr_o same sequence, no gaps after fill.
REQ-033 ready=0 with DEPTH=4 -> exactly 4 grants, then req_o=0; FIFO holds addrs 0,4,8,12; ready=1 resumes requests at 16.
REQ-034 2 outstanding, flush_i with flush_addr_i=32'h100 -> next two rvalid_i dropped; first inst_addr_o after flush=32'h100.
REQ-035 flush_i same cycle as rvalid_i and pop -> that response dropped, FIFO empty next cycle, req_o resumes at flush_addr_i.
REQ-036 hold_i=1 for 5 cycles -> no grants, buffered instructions still drain; PC unchanged at 0x20 throughout.
REQ-037 IFBUF_FWD_EN on vs off, empty FIFO, rvalid_i at cycle N -> inst_valid_o at N (on) vs N+1 (off).
